julia_iter_seq: RTL and testbench

- Iteration sequencer and initiator for the single-step Julia calculator interface (enable / working / xN / yN / dout).
- Accepts one point job (z0, c) from the pixel scan logic. Repeatedly issues z -> z^2 + c steps to the calculator, feeding each result back as the next operand.
- Stops on escape or on reaching the iteration limit, then reports the iteration count for colour mapping.

---
 rtl/julia_iter_seq.sv | 145 ++++++++++++++
 tb/tb_julia_iter_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/julia_iter_seq.sv
// Julia iteration sequencer: drives a single-step z^2+c calculator
// until escape, iteration cap or calculator timeout.
module julia_iter_seq #(
  parameter int MAX_ITER    = 255,
  parameter int ITER_W      = 8,
  parameter int ESC_LIMIT   = 4194304,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic signed [31:0]  x0,
  input  logic signed [31:0]  y0,
  input  logic signed [31:0]  cr,
  input  logic signed [31:0]  ci,
  output logic                busy,
  output logic                done,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic                escaped,
  output logic                err,
  output logic                calc_en,
  output logic signed [31:0]  calc_x,
  output logic signed [31:0]  calc_y,
  output logic signed [31:0]  calc_cr,
  output logic signed [31:0]  calc_ci,
  input  logic                calc_done,
  input  logic signed [31:0]  calc_xn,
  input  logic signed [31:0]  calc_yn,
  input  logic signed [31:0]  calc_mag
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam logic signed [31:0] ESC = ESC_LIMIT;
  localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);
  localparam logic [ITER_W-1:0] CAP = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL,
    FIN
  } state_t;

  state_t              state;
  logic [ITER_W-1:0]   cnt;
  logic [TW-1:0]       tmo;
  logic signed [31:0]  xn_q;
  logic signed [31:0]  yn_q;
  logic signed [31:0]  mag_q;
  logic                esc_hit;
  logic                at_cap;

  // Negative magnitude means the calculator overflowed: treat as escape.
  assign esc_hit = (mag_q > ESC) || mag_q[31];
  assign at_cap  = (cnt == CAP);

  // Job sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      iter_cnt <= '0;
      escaped  <= 1'b0;
      err      <= 1'b0;
      calc_en  <= 1'b0;
      calc_x   <= '0;
      calc_y   <= '0;
      calc_cr  <= '0;
      calc_ci  <= '0;
      cnt      <= '0;
      tmo      <= '0;
      xn_q     <= '0;
      yn_q     <= '0;
      mag_q    <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        calc_en <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              calc_x   <= x0;
              calc_y   <= y0;
              calc_cr  <= cr;
              calc_ci  <= ci;
              cnt      <= '0;
              tmo      <= '0;
              iter_cnt <= '0;
              escaped  <= 1'b0;
              err      <= 1'b0;
              busy     <= 1'b1;
              calc_en  <= 1'b1;
              state    <= REQ;
            end
          end
          REQ: begin
            if (calc_done) begin
              xn_q    <= calc_xn;
              yn_q    <= calc_yn;
              mag_q   <= calc_mag;
              cnt     <= cnt + 1'b1;
              calc_en <= 1'b0;
              state   <= REL;
            end else if (tmo == TMO_LAST) begin
              calc_en  <= 1'b0;
              err      <= 1'b1;
              escaped  <= 1'b0;
              iter_cnt <= cnt;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= FIN;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          REL: begin
            if (esc_hit || at_cap) begin
              escaped  <= esc_hit;
              iter_cnt <= cnt;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= FIN;
            end else begin
              calc_x  <= xn_q;
              calc_y  <= yn_q;
              tmo     <= '0;
              calc_en <= 1'b1;
              state   <= REQ;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_julia_iter_seq.sv
// Bench for julia_iter_seq: behavioural calculator plus
// a result scoreboard.
module tb_julia_iter_seq;

  typedef struct packed {
    logic [7:0] it;
    logic       esc;
    logic       er;
  } res_t;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic abort = 0;
  logic signed [31:0] x0 = 0, y0 = 0, cr = 0, ci = 0;
  logic busy, done, escaped, err, calc_en;
  logic [7:0] iter_cnt;
  logic signed [31:0] calc_x, calc_y, calc_cr, calc_ci;
  logic calc_done;
  logic signed [31:0] calc_xn, calc_yn, calc_mag;

  int n_run = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int en_cycles = 0;
  int en_rises = 0;
  int cr_bad = 0;
  logic en_prev = 0;
  logic silent = 0;
  logic signed [31:0] exp_cr = 0, exp_ci = 0;
  res_t sb[$];

  julia_iter_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .cr(cr), .ci(ci),
    .busy(busy), .done(done), .iter_cnt(iter_cnt),
    .escaped(escaped), .err(err), .calc_en(calc_en),
    .calc_x(calc_x), .calc_y(calc_y),
    .calc_cr(calc_cr), .calc_ci(calc_ci),
    .calc_done(calc_done), .calc_xn(calc_xn),
    .calc_yn(calc_yn), .calc_mag(calc_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Calculator model: one result one cycle after calc_en rises.
  always @(posedge clk or negedge rst_n) begin
    longint x, y, xn, yn;
    if (!rst_n) begin
      calc_done <= 0;
      calc_xn <= 0;
      calc_yn <= 0;
      calc_mag <= 0;
    end else if (calc_en && !calc_done && !silent) begin
      x = calc_x;
      y = calc_y;
      xn = ((x * x - y * y) >>> 10) + calc_cr;
      yn = ((2 * x * y) >>> 10) + calc_ci;
      calc_done <= 1;
      calc_xn <= 32'(xn);
      calc_yn <= 32'(yn);
      calc_mag <= 32'(xn * xn + yn * yn);
    end else begin
      calc_done <= 0;
    end
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (calc_en) en_cycles++;
      if (calc_en && !en_prev) en_rises++;
      en_prev = calc_en;
      if (busy && (calc_cr != exp_cr || calc_ci != exp_ci))
        cr_bad++;
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("iter_cnt", iter_cnt, e.it);
          chk("escaped", escaped, e.esc);
          chk("err", err, e.er);
        end
      end
    end else begin
      en_prev = 0;
    end
  end

  task automatic go(input int ax, input int ay, input int acr,
                    input int aci, input bit push, input res_t r);
    @(negedge clk);
    x0 = ax; y0 = ay; cr = acr; ci = aci;
    exp_cr = acr; exp_ci = aci;
    if (push) sb.push_back(r);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    chk("done_in_time", (done_cnt != d0), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, e0, r0;
    res_t r1, r2, rt;
    r1 = '{it: 8'd2, esc: 1'b1, er: 1'b0};
    r2 = '{it: 8'd255, esc: 1'b0, er: 1'b0};
    rt = '{it: 8'd0, esc: 1'b0, er: 1'b1};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", calc_en, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_x", calc_x, 0);
    chk("rst_cr", calc_cr, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // escape on second iteration, first at exact limit
    d0 = done_cnt; r0 = en_rises;
    go(0, 0, 2048, 0, 1, r1);
    chk("busy_after_start", busy, 1);
    chk("cr_latched", calc_cr, 2048);
    wait_done(d0, 100);
    chk("esc_en_rises", en_rises - r0, 2);
    chk("en_low_after", calc_en, 0);
    chk("held_iter", iter_cnt, 2);

    // never escapes: run to the cap
    d0 = done_cnt; r0 = en_rises; cr_bad = 0;
    go(0, 0, 0, 0, 1, r2);
    wait_done(d0, 2000);
    chk("cap_en_rises", en_rises - r0, 255);
    chk("cr_const", cr_bad, 0);

    // silent calculator -> timeout
    silent = 1;
    d0 = done_cnt; e0 = en_cycles;
    go(0, 0, 2048, 0, 1, rt);
    wait_done(d0, 200);
    chk("tmo_en_cycles", en_cycles - e0, 64);
    chk("tmo_en_low", calc_en, 0);
    silent = 0;

    // second start while busy is ignored
    d0 = done_cnt;
    go(0, 0, 2048, 0, 1, r1);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(d0, 100);
    repeat (10) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);

    // abort during first request
    d0 = done_cnt;
    go(0, 0, 2048, 0, 0, r1);
    chk("pre_abort_en", calc_en, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_en", calc_en, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    go(0, 0, 2048, 0, 1, r1);
    wait_done(d0, 100);

    // async reset in the middle of a request
    go(0, 0, 2048, 0, 0, r1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", calc_en, 0);
    chk("mid_rst_x", calc_x, 0);
    chk("mid_rst_cr", calc_cr, 0);
    chk("mid_rst_iter", iter_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    go(0, 0, 2048, 0, 1, r1);
    wait_done(d0, 100);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
